// File: rtl/stream_upsize_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stream_upsize_ctrl
// Purpose  : Stream width upsizer. Packs T_DATA_RATIO narrow input beats
//            (T_DATA_WIDTH bits each) into one wide output word of
//            T_DATA_RATIO lanes. Lane 0 holds the first beat of the word.
//            A packet end (s_last_i) closes a partial word early. Lanes that
//            do not carry a beat are flagged by m_keep_o and driven to 0.
//            When the downstream sink takes the word, the first beat of the
//            next word can be accepted in the same cycle, so a continuous
//            stream runs at one beat per cycle.
// Ports    : clk_i      - clock, rising edge
//            rst_n_i    - asynchronous active-low reset
//            s_data_i   - input beat data
//            s_last_i   - input beat ends the packet
//            s_valid_i  - input beat valid
//            s_ready_o  - block accepts an input beat
//            m_data_o   - output word, T_DATA_RATIO lanes
//            m_keep_o   - per-lane valid flags
//            m_last_o   - output word ends the packet
//            m_valid_o  - output word valid
//            m_ready_i  - downstream accepts the word
// Revision : 1.0 - initial release
// ============================================================================
module stream_upsize_ctrl #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO],
    output logic [T_DATA_RATIO-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int CNT_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
    localparam logic [CNT_W-1:0] C_LAST_LANE = CNT_W'(T_DATA_RATIO - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [T_DATA_WIDTH-1:0] r_lane     [T_DATA_RATIO];
    logic [T_DATA_WIDTH-1:0] w_lane_nxt [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] r_keep;
    logic [T_DATA_RATIO-1:0] w_keep_nxt;
    logic                    r_last;
    logic                    w_last_nxt;

    logic                    w_s_ready;
    logic                    w_s_hs;
    logic                    w_m_hs;

    // ------------------------------------------------------------------
    // Handshakes. Ready is gated by reset so nothing is offered upstream
    // while the block is held in reset; in SEND a new beat can only enter
    // when the held word is leaving in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_s_ready = 1'b0;
        if (rst_n_i) begin
            w_s_ready = (r_state == FILL) ? 1'b1 : m_ready_i;
        end
    end

    assign w_s_hs = s_valid_i && w_s_ready;
    assign w_m_hs = (r_state == SEND) && m_ready_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                r_lane[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_keep  <= w_keep_nxt;
            r_last  <= w_last_nxt;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                r_lane[i] <= w_lane_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_keep_nxt  = r_keep;
        w_last_nxt  = r_last;
        for (int i = 0; i < T_DATA_RATIO; i++) begin
            w_lane_nxt[i] = r_lane[i];
        end

        case (r_state)
            FILL: begin
                if (w_s_hs) begin
                    // Lane select by compare so non-power-of-two ratios
                    // never index past the last lane.
                    for (int i = 0; i < T_DATA_RATIO; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            w_lane_nxt[i] = s_data_i;
                            w_keep_nxt[i] = 1'b1;
                        end
                    end
                    if ((r_cnt == C_LAST_LANE) || s_last_i) begin
                        w_state_nxt = SEND;
                        w_last_nxt  = s_last_i;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + C_CNT_ONE;
                    end
                end
            end

            SEND: begin
                if (w_m_hs) begin
                    // The held word leaves; start from a clean word so lanes
                    // without a beat read back as zero.
                    w_keep_nxt = '0;
                    w_last_nxt = 1'b0;
                    w_cnt_nxt  = '0;
                    for (int i = 0; i < T_DATA_RATIO; i++) begin
                        w_lane_nxt[i] = '0;
                    end
                    if (w_s_hs) begin
                        // Incoming beat becomes lane 0 of the next word.
                        w_lane_nxt[0] = s_data_i;
                        w_keep_nxt[0] = 1'b1;
                        if (s_last_i) begin
                            // Single-beat packet: the new word is already
                            // complete, so stay in SEND.
                            w_state_nxt = SEND;
                            w_last_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = FILL;
                            w_cnt_nxt   = C_CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = FILL;
                    end
                end
            end

            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Lanes are masked with keep so an unused lane is zero even
    // if the stored value were ever stale.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < T_DATA_RATIO; gi++) begin : g_lane
            assign m_data_o[gi] = r_keep[gi] ? r_lane[gi] : '0;
        end
    endgenerate

    assign s_ready_o = w_s_ready;
    assign m_keep_o  = r_keep;
    assign m_last_o  = r_last;
    assign m_valid_o = (r_state == SEND);

endmodule
`default_nettype wire

// File: tb/tb_stream_upsize_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_upsize_ctrl
// Purpose  : Self-checking bench for stream_upsize_ctrl with 8-bit beats
//            packed four to a word. A table of per-cycle vectors covers full
//            words, short packets, backpressure and single-beat packets;
//            hand-written sequences cover reset mid-word, reset while a word
//            is held, and back-to-back streaming.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_upsize_ctrl;

    localparam int W = 8;
    localparam int R = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] s_data;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] m_data [R];
    logic [R-1:0] m_keep;
    logic         m_last;
    logic         m_valid;
    logic         m_ready;

    int n_total;
    int n_pass;

    // Words observed leaving the DUT in the hand-written sequences
    logic [31:0] q_data [$];
    logic [3:0]  q_keep [$];
    logic        q_last [$];

    typedef struct packed {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        mr;
        logic        e_sr;
        logic        e_mv;
        logic [3:0]  e_keep;
        logic        e_last;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [22];

    stream_upsize_ctrl #(
        .T_DATA_WIDTH (W),
        .T_DATA_RATIO (R)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_keep_o  (m_keep),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] packed_data();
        return {m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, record any output handshake, then clock.
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic l,
                               input logic mr, output logic sr_seen);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
        #1;
        sr_seen = s_ready;
        if (m_valid && m_ready) begin
            q_data.push_back(packed_data());
            q_keep.push_back(m_keep);
            q_last.push_back(m_last);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic sr;
        logic all_ready;

        n_total = 0;
        n_pass  = 0;

        //              v  d      l  mr   sr mv keep  last data
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 32'h00000000};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 32'h00000011};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 32'h00002211};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 1'b0, 32'h00332211};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 32'h44332211};
        tbl[5]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 32'h00000000};
        tbl[6]  = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 32'h00000055};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 32'h00006655};
        tbl[8]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 32'h00006655};
        tbl[9]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 32'h00006655};
        tbl[10] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 32'h00006655};
        tbl[11] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 32'h00006655};
        tbl[12] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1, 32'h00006655};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 32'h00000077};
        tbl[14] = '{1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 32'h00000077};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 32'h00008877};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1, 32'h00008877};
        tbl[17] = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 32'h00000000};
        tbl[18] = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 32'h00000099};
        tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 32'h000000AA};
        tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 32'h000000AA};
        tbl[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 32'h00000000};

        // ---------------- reset state ----------------
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.sready", {31'd0, s_ready}, 32'd0);
        check("rst.mvalid", {31'd0, m_valid}, 32'd0);
        check("rst.keep",   {28'd0, m_keep},  32'd0);
        check("rst.last",   {31'd0, m_last},  32'd0);
        check("rst.data",   packed_data(),    32'd0);

        // Release between edges; the first vector is taken on the next edge.
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int k = 0; k < 22; k++) begin
            s_valid = tbl[k].v;
            s_data  = tbl[k].d;
            s_last  = tbl[k].l;
            m_ready = tbl[k].mr;
            #1;
            check($sformatf("vec%0d.sready", k), {31'd0, s_ready}, {31'd0, tbl[k].e_sr});
            check($sformatf("vec%0d.mvalid", k), {31'd0, m_valid}, {31'd0, tbl[k].e_mv});
            check($sformatf("vec%0d.keep", k),   {28'd0, m_keep},  {28'd0, tbl[k].e_keep});
            check($sformatf("vec%0d.last", k),   {31'd0, m_last},  {31'd0, tbl[k].e_last});
            check($sformatf("vec%0d.data", k),   packed_data(),    tbl[k].e_data);
            @(posedge clk);
            #1;
        end

        // ---------------- reset mid-word ----------------
        drive_cycle(1'b1, 8'h01, 1'b0, 1'b1, sr);
        drive_cycle(1'b1, 8'h02, 1'b0, 1'b1, sr);
        s_valid = 1'b0;
        check("midword.keep_before", {28'd0, m_keep}, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midword.rst_keep",   {28'd0, m_keep},  32'd0);
        check("midword.rst_mvalid", {31'd0, m_valid}, 32'd0);
        check("midword.rst_sready", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        drive_cycle(1'b1, 8'h03, 1'b0, 1'b1, sr);
        check("midword.first_sready", {31'd0, sr}, 32'd1);
        drive_cycle(1'b1, 8'h04, 1'b0, 1'b1, sr);
        drive_cycle(1'b1, 8'h05, 1'b0, 1'b1, sr);
        drive_cycle(1'b1, 8'h06, 1'b0, 1'b1, sr);
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, sr);
        check("midword.nwords", q_data.size(), 32'd1);
        if (q_data.size() > 0) begin
            check("midword.data", q_data[0], 32'h06050403);
            check("midword.keep", {28'd0, q_keep[0]}, 32'hF);
            check("midword.last", {31'd0, q_last[0]}, 32'd0);
        end

        // ---------------- reset while a word is held ----------------
        drive_cycle(1'b1, 8'h0F, 1'b1, 1'b0, sr);
        s_valid = 1'b0;
        check("sendrst.mvalid_before", {31'd0, m_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("sendrst.mvalid", {31'd0, m_valid}, 32'd0);
        check("sendrst.keep",   {28'd0, m_keep},  32'd0);
        check("sendrst.last",   {31'd0, m_last},  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- streaming ----------------
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        all_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1'b1, 8'(i + 1), (i == 11), 1'b1, sr);
            all_ready = all_ready & sr;
        end
        repeat (2) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, sr);
        check("stream.sready_always", {31'd0, all_ready}, 32'd1);
        check("stream.nwords", q_data.size(), 32'd3);
        for (int w = 0; w < 3; w++) begin
            if (w < q_data.size()) begin
                check($sformatf("stream.w%0d.data", w), q_data[w],
                      {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)});
                check($sformatf("stream.w%0d.keep", w), {28'd0, q_keep[w]}, 32'hF);
                check($sformatf("stream.w%0d.last", w), {31'd0, q_last[w]}, {31'd0, (w == 2)});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
